// File: rtl/uart_trx_pkg.sv
// Shared types and constants for the uart_trx full-duplex UART.
// Both FSM states are collected in dbg_t so they can be observed from outside.
package uart_trx_pkg;

  localparam int OVS         = 16;
  localparam int SAMPLE_TICK = 7;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  typedef struct packed {
    tx_state_e tx_state;
    rx_state_e rx_state;
  } dbg_t;

  function automatic logic parity_en(parity_e p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_trx_tick.sv
// Oversample tick divider: fires when count equals the latched divider, then wraps.
// clr_i restarts the count and latches a new divider value.
module uart_trx_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_an_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;

  assign tick_o = (cnt_q == div_q);

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      div_q <= div_i;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_trx.sv
// Full-duplex UART with per-frame latched config, parity/stop modes and rx error flags.
// Streams: a word moves when valid & ready are both high on a clock edge; valid never waits on ready.
module uart_trx
  import uart_trx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_an_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [1:0]            cfg_parity_i,
  input  logic                  cfg_stop2_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_overrun_o,
  input  logic                  rxd_i,
  output logic                  txd_o,
  output logic                  busy_o,
  output dbg_t                  dbg_o
);

  parity_e cfg_par;
  assign cfg_par = parity_e'(cfg_parity_i);

  // ---------------- transmitter ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [3:0]            tx_ovs_q, tx_bit_q;
  logic                  tx_par_bit_q, tx_par_en_q, tx_stop2_q, txd_q, tx_line;
  logic                  tx_tick, tx_accept, tx_bit_end;

  assign tx_ready_o = (tx_state_q == TX_IDLE);
  assign tx_accept  = tx_valid_i & tx_ready_o;
  assign tx_bit_end = tx_tick & (tx_ovs_q == 4'(OVS - 1));

  uart_trx_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
    .clk_i(main_clk_i), .rst_an_i(main_rst_an_i), .clr_i(tx_accept),
    .div_i(cfg_div_i), .tick_o(tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_line    = 1'b1;
    case (tx_state_q)
      TX_IDLE:   if (tx_accept) tx_state_d = TX_START;
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_bit_end && tx_bit_q == 4'(DATA_WIDTH - 1))
          tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_line = tx_par_bit_q;
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
      TX_STOP:   if (tx_bit_end && (!tx_stop2_q || tx_bit_q == 4'd1)) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // txd is the line value registered one clock behind the state, so it falls the clock after accept.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      tx_state_q   <= TX_IDLE;
      txd_q        <= 1'b1;
      tx_shift_q   <= '0;
      tx_ovs_q     <= '0;
      tx_bit_q     <= '0;
      tx_par_bit_q <= 1'b0;
      tx_par_en_q  <= 1'b0;
      tx_stop2_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      txd_q      <= tx_line;
      if (tx_accept) begin
        tx_shift_q   <= tx_data_i;
        tx_ovs_q     <= '0;
        tx_bit_q     <= '0;
        tx_par_bit_q <= (^tx_data_i) ^ (cfg_par == PAR_ODD);
        tx_par_en_q  <= parity_en(cfg_par);
        tx_stop2_q   <= cfg_stop2_i;
      end else if (tx_tick && tx_state_q != TX_IDLE) begin
        tx_ovs_q <= tx_ovs_q + 4'd1;
        if (tx_bit_end) begin
          tx_bit_q <= (tx_state_d != tx_state_q) ? 4'd0 : tx_bit_q + 4'd1;
          if (tx_state_q == TX_DATA) tx_shift_q <= tx_shift_q >> 1;
        end
      end
    end
  end

  assign txd_o = txd_q;

  // ---------------- receiver ----------------
  rx_state_e             rx_state_q, rx_state_d;
  logic                  rx_s1_q, rx_s2_q, rx_s3_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_data_q;
  logic [3:0]            rx_ovs_q, rx_bit_q;
  logic                  rx_par_q, rx_par_en_q, rx_odd_q;
  logic                  rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q, busy_q;
  logic                  rx_tick, rx_fall, rx_start, rx_sample, rx_bit_end, rx_done;

  assign rx_fall    = rx_s3_q & ~rx_s2_q;
  assign rx_start   = (rx_state_q == RX_IDLE) & rx_fall;
  assign rx_sample  = rx_tick & (rx_ovs_q == 4'(SAMPLE_TICK));
  assign rx_bit_end = rx_tick & (rx_ovs_q == 4'(OVS - 1));

  uart_trx_tick #(.DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
    .clk_i(main_clk_i), .rst_an_i(main_rst_an_i), .clr_i(rx_start),
    .div_i(cfg_div_i), .tick_o(rx_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE:   if (rx_fall) rx_state_d = RX_START;
      RX_START: begin
        if (rx_sample && rx_s2_q) rx_state_d = RX_IDLE;
        else if (rx_bit_end)      rx_state_d = RX_DATA;
      end
      RX_DATA:   if (rx_bit_end && rx_bit_q == 4'(DATA_WIDTH - 1))
                   rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_bit_end) rx_state_d = RX_STOP;
      RX_STOP: begin
        if (rx_sample) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default:   rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rx_state_q  <= RX_IDLE;
      rx_shift_q  <= '0;
      rx_ovs_q    <= '0;
      rx_bit_q    <= '0;
      rx_par_q    <= 1'b0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      if (rx_start) begin
        rx_ovs_q    <= '0;
        rx_bit_q    <= '0;
        rx_par_en_q <= parity_en(cfg_par);
        rx_odd_q    <= (cfg_par == PAR_ODD);
      end else if (rx_tick && rx_state_q != RX_IDLE) begin
        rx_ovs_q <= rx_ovs_q + 4'd1;
        if (rx_sample && rx_state_q == RX_DATA)   rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
        if (rx_sample && rx_state_q == RX_PARITY) rx_par_q   <= rx_s2_q;
        if (rx_bit_end) rx_bit_q <= (rx_state_d != rx_state_q) ? 4'd0 : rx_bit_q + 4'd1;
      end
    end
  end

  // A ready in the completion cycle frees the slot, so the new word loads instead of overrunning.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      busy_q   <= (tx_state_d != TX_IDLE) | (rx_state_d != RX_IDLE);
      if (rx_done) begin
        if (rx_valid_q && !rx_ready_i) begin
          rx_ovr_q <= 1'b1;
        end else begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
          rx_perr_q  <= rx_par_en_q & (rx_par_q ^ (^rx_shift_q) ^ rx_odd_q);
          rx_ferr_q  <= ~rx_s2_q;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_q;
  assign rx_frame_err_o  = rx_ferr_q;
  assign rx_overrun_o    = rx_ovr_q;
  assign busy_o          = busy_q;
  assign dbg_o           = '{tx_state: tx_state_q, rx_state: rx_state_q};

endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx: TX waveform, loopback, rx errors, overrun, glitch and reset.
module tb_uart_trx;
  import uart_trx_pkg::*;

  localparam int DW  = 8;
  localparam int DVW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DVW-1:0] cfg_div = '0;
  logic [1:0]     cfg_parity = 2'd0;
  logic           cfg_stop2 = 1'b0;
  logic [DW-1:0]  tx_data = '0;
  logic           tx_valid = 1'b0;
  logic           tx_ready;
  logic [DW-1:0]  rx_data;
  logic           rx_valid;
  logic           rx_ready = 1'b0;
  logic           rx_perr, rx_ferr, rx_ovr;
  logic           rxd, txd, busy;
  logic           loop_en = 1'b0;
  logic           rxd_drv = 1'b1;
  dbg_t           dbg;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_trx #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .main_clk_i(clk), .main_rst_an_i(rst_n),
    .cfg_div_i(cfg_div), .cfg_parity_i(cfg_parity), .cfg_stop2_i(cfg_stop2),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_parity_err_o(rx_perr), .rx_frame_err_o(rx_ferr), .rx_overrun_o(rx_ovr),
    .rxd_i(rxd), .txd_o(txd), .busy_o(busy), .dbg_o(dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] got_q[$];
  int ovr_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_perr, rx_ferr, rx_data});
    if (rx_ovr) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [DW-1:0] d, output int acc_cyc);
    logic rdy;
    bit   done;
    done     = 0;
    acc_cyc  = -1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 5000 && !done; i++) begin
      rdy = tx_ready;
      cycles(1);
      if (rdy) begin
        done    = 1;
        acc_cyc = cyc;
      end
    end
    tx_valid = 1'b0;
    if (!done) check("tx_accept_timeout", 32'd0, 32'd1);
  endtask

  // Called right after the accept edge; div=0, 8 data bits, no parity, one stop bit.
  task automatic check_tx_wave(input string tag, input logic [DW-1:0] d);
    logic exp_bit;
    int   idx;
    for (int k = 1; k <= 160; k++) begin
      cycles(1);
      if (k % 16 == 8) begin
        idx = k / 16;
        exp_bit = (idx == 0) ? 1'b0 : (idx <= 8) ? d[idx-1] : 1'b1;
        check($sformatf("%s_bit%0d", tag, idx), {31'd0, txd}, {31'd0, exp_bit});
      end
      if (k == 159) check({tag, "_ready_early"}, {31'd0, tx_ready}, 32'd0);
      if (k == 160) check({tag, "_ready_back"}, {31'd0, tx_ready}, 32'd1);
    end
  endtask

  task automatic rx_bit(input logic b);
    rxd_drv = b;
    cycles(16);
  endtask

  // div=0 frame; rdy_pulse raises rx_ready exactly in the stop-sample cycle (no-parity frames).
  task automatic rx_frame(input logic [DW-1:0] d, input bit has_par, input logic par,
                          input logic stop, input bit rdy_pulse);
    rx_bit(1'b0);
    for (int i = 0; i < DW; i++) rx_bit(d[i]);
    if (has_par) rx_bit(par);
    rxd_drv = stop;
    if (rdy_pulse) begin
      cycles(10);
      rx_ready = 1'b1;
      cycles(1);
      rx_ready = 1'b0;
      cycles(5);
    end else begin
      cycles(16);
    end
    rxd_drv = 1'b1;
    cycles(16);
  endtask

  task automatic expect_rx(input string tag, input logic [DW+1:0] e);
    check({tag, "_count"}, got_q.size(), 32'd1);
    if (got_q.size() > 0) check(tag, {22'd0, got_q.pop_front()}, {22'd0, e});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a0, a1, a2;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_errs", {29'd0, rx_perr, rx_ferr, rx_ovr}, 32'd0);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_txd", {31'd0, txd}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // TX waveform: div=0, no parity, one stop bit, 0xA5
    send_tx(8'hA5, a0);
    check("tx_fall_pending", {31'd0, txd}, 32'd1);
    check("tx_busy", {31'd0, busy}, 32'd1);
    check_tx_wave("tx_a5", 8'hA5);

    // Loopback: div=3, even parity, two stop bits; 768-clock frames plus the IDLE handshake cycle
    cfg_div = 16'd3; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    loop_en = 1'b1; rx_ready = 1'b1;
    cycles(2);
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'hFF});
    exp_q.push_back({2'b00, 8'h3C});
    send_tx(8'h00, a0);
    send_tx(8'hFF, a1);
    send_tx(8'h3C, a2);
    check("lb_interval1", a1 - a0, 32'd769);
    check("lb_interval2", a2 - a1, 32'd769);
    for (int i = 0; i < 3000 && got_q.size() < 3; i++) cycles(1);
    check("lb_count", got_q.size(), 32'd3);
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("lb_word", {22'd0, got_q.pop_front()}, {22'd0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
    cycles(100);
    loop_en = 1'b0;
    cfg_div = 16'd0; cfg_stop2 = 1'b0;
    cycles(5);

    // Parity and framing errors (div=0)
    cfg_parity = 2'd2;
    rx_frame(8'h81, 1, 1'b0, 1'b1, 0);
    expect_rx("odd_bad_par", {2'b10, 8'h81});
    rx_frame(8'h81, 1, 1'b1, 1'b1, 0);
    expect_rx("odd_good_par", {2'b00, 8'h81});
    rx_frame(8'h55, 1, 1'b1, 1'b0, 0);
    expect_rx("stop_low", {2'b01, 8'h55});
    cfg_parity = 2'd1;
    rx_frame(8'h03, 1, 1'b1, 1'b1, 0);
    expect_rx("even_bad_par", {2'b10, 8'h03});

    // Overrun: two frames with no consumer
    cfg_parity = 2'd0;
    rx_ready = 1'b0;
    rx_frame(8'h11, 0, 1'b0, 1'b1, 0);
    rx_frame(8'h22, 0, 1'b0, 1'b1, 0);
    check("ovr_pulses", ovr_cnt, 32'd1);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    expect_rx("ovr_drain", {2'b00, 8'h11});
    check("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);

    // Ready in the completion cycle: no overrun, new word loads
    rx_frame(8'h11, 0, 1'b0, 1'b1, 0);
    rx_frame(8'h22, 0, 1'b0, 1'b1, 1);
    check("same_cyc_no_ovr", ovr_cnt, 32'd1);
    check("same_cyc_valid", {31'd0, rx_valid}, 32'd1);
    check("same_cyc_data", {24'd0, rx_data}, 32'h22);
    expect_rx("same_cyc_consumed", {2'b00, 8'h11});
    rx_ready = 1'b1;
    cycles(2);
    expect_rx("same_cyc_drain", {2'b00, 8'h22});

    // Glitch start: low for 5 clocks
    rxd_drv = 1'b0;
    cycles(4);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    cycles(1);
    rxd_drv = 1'b1;
    cycles(30);
    check("glitch_no_word", got_q.size(), 32'd0);
    check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_rx_idle", {29'd0, dbg.rx_state}, {29'd0, RX_IDLE});
    check("glitch_busy_drop", {31'd0, busy}, 32'd0);

    // Reset mid-frame during TX DATA (bit1 of 0xA5 is 0)
    send_tx(8'hA5, a0);
    cycles(40);
    check("mid_txd_low", {31'd0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    check("mid_rel_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rel_busy", {31'd0, busy}, 32'd0);
    send_tx(8'h3C, a0);
    check_tx_wave("tx_3c", 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
